// File: rtl/rx_peak_detector_pkg.sv
// Shared types and default widths for the receive peak detector.
package rx_peak_detector_pkg;

  // FSM state encodings
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_TRACK  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  // Defaults shared with the receive FIR accumulator
  localparam int unsigned DEF_DATA_W   = 41;
  localparam int unsigned DEF_IDX_W    = 16;
  localparam int unsigned DEF_WINDOW   = 64;
  localparam int unsigned DEF_MAX_WAIT = 4096;

endpackage

// File: rtl/rx_peak_detector_abs_sat.sv
// Registered saturating absolute value of a signed sample.
module rx_abs_sat
  import rx_peak_detector_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] sample,
  output logic [DATA_W-1:0]        mag
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] POS_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] raw_c;
  logic [DATA_W-1:0] abs_c;

  // Two's-complement negate, with the most negative code clamped to the largest positive
  always_comb begin
    raw_c = $unsigned(sample);
    abs_c = raw_c;
    if (raw_c == MOST_NEG) begin
      abs_c = POS_MAX;
    end else if (raw_c[DATA_W-1]) begin
      abs_c = ~raw_c + DATA_W'(1);
    end
  end

  // Capture the magnitude on each sample strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag <= '0;
    end else if (clr) begin
      mag <= '0;
    end else if (load) begin
      mag <= abs_c;
    end
  end

endmodule

// File: rtl/rx_peak_detector.sv
// Threshold-triggered windowed peak detector behind the receive FIR filter.
module rx_peak_detector
  import rx_peak_detector_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned WINDOW   = DEF_WINDOW,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned IDX_W    = DEF_IDX_W
) (
  input  logic                     crx_clk,
  input  logic                     rrx_rst,
  input  logic                     erx_en,
  input  logic signed [DATA_W-1:0] isample,
  input  logic                     inew_sample,
  input  logic [DATA_W-1:0]        ithreshold,
  input  logic                     istart,
  output logic                     obusy,
  output logic                     opeak_valid,
  output logic                     odetected,
  output logic [DATA_W-1:0]        opeak_value,
  output logic [IDX_W-1:0]         opeak_index
);

  localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t             state;
  logic [DATA_W-1:0]  mag;
  logic               tag;
  logic [DATA_W-1:0]  peak_mag;
  logic [IDX_W-1:0]   peak_idx;
  logic [IDX_W-1:0]   idx_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [WAIT_W-1:0]  wait_cnt;

  logic               better_c;
  logic [IDX_W-1:0]   idx_next_c;
  logic [DATA_W-1:0]  track_peak_c;
  logic [IDX_W-1:0]   track_idx_c;

  // Stage 1 magnitude
  rx_abs_sat #(
    .DATA_W (DATA_W)
  ) u_abs (
    .clk    (crx_clk),
    .rst    (rrx_rst),
    .clr    (~erx_en),
    .load   (inew_sample),
    .sample (isample),
    .mag    (mag)
  );

  // Stage 1 count tag: only samples strobed while armed or tracking are counted
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      tag <= 1'b0;
    end else if (!erx_en) begin
      tag <= 1'b0;
    end else begin
      tag <= inew_sample && ((state == ST_ARMED) || (state == ST_TRACK));
    end
  end

  // Saturating index increment and strictly-greater peak candidate (ties keep earliest)
  always_comb begin
    better_c     = 1'b0;
    idx_next_c   = idx_cnt;
    track_peak_c = peak_mag;
    track_idx_c  = peak_idx;
    if (idx_cnt != {IDX_W{1'b1}}) begin
      idx_next_c = idx_cnt + IDX_W'(1);
    end
    if (mag > peak_mag) begin
      better_c = 1'b1;
    end
    if (better_c) begin
      track_peak_c = mag;
      track_idx_c  = idx_cnt;
    end
  end

  // Stage 2 FSM, counters, peak registers and registered outputs
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      state       <= ST_IDLE;
      peak_mag    <= '0;
      peak_idx    <= '0;
      idx_cnt     <= '0;
      win_cnt     <= '0;
      wait_cnt    <= '0;
      obusy       <= 1'b0;
      opeak_valid <= 1'b0;
      odetected   <= 1'b0;
      opeak_value <= '0;
      opeak_index <= '0;
    end else if (!erx_en) begin
      state       <= ST_IDLE;
      peak_mag    <= '0;
      peak_idx    <= '0;
      idx_cnt     <= '0;
      win_cnt     <= '0;
      wait_cnt    <= '0;
      obusy       <= 1'b0;
      opeak_valid <= 1'b0;
      odetected   <= 1'b0;
      opeak_value <= '0;
      opeak_index <= '0;
    end else begin
      opeak_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (istart) begin
            state       <= ST_ARMED;
            obusy       <= 1'b1;
            peak_mag    <= '0;
            peak_idx    <= '0;
            idx_cnt     <= '0;
            win_cnt     <= '0;
            wait_cnt    <= '0;
            odetected   <= 1'b0;
            opeak_value <= '0;
            opeak_index <= '0;
          end
        end
        ST_ARMED: begin
          if (tag) begin
            idx_cnt <= idx_next_c;
            if (mag >= ithreshold) begin
              peak_mag <= mag;
              peak_idx <= idx_cnt;
              win_cnt  <= WIN_W'(1);
              if (WINDOW == 1) begin
                state       <= ST_REPORT;
                opeak_valid <= 1'b1;
                odetected   <= 1'b1;
                opeak_value <= mag;
                opeak_index <= idx_cnt;
              end else begin
                state <= ST_TRACK;
              end
            end else if (wait_cnt == WAIT_LAST) begin
              state       <= ST_REPORT;
              opeak_valid <= 1'b1;
              odetected   <= 1'b0;
              opeak_value <= '0;
              opeak_index <= '0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
        end
        ST_TRACK: begin
          if (tag) begin
            idx_cnt  <= idx_next_c;
            peak_mag <= track_peak_c;
            peak_idx <= track_idx_c;
            win_cnt  <= win_cnt + WIN_W'(1);
            if (win_cnt == WIN_LAST) begin
              state       <= ST_REPORT;
              opeak_valid <= 1'b1;
              odetected   <= 1'b1;
              opeak_value <= track_peak_c;
              opeak_index <= track_idx_c;
            end
          end
        end
        ST_REPORT: begin
          state <= ST_IDLE;
          obusy <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          obusy <= 1'b0;
        end
      endcase
    end
  end

endmodule
